// File: rtl/uart_core.sv
// Full-duplex UART with a shared 16x oversampling tick, ready/valid TX and glitch-filtered RX.
// Optional parity bit in both directions when UART_PARITY_EN is defined (sense set by PARITY_ODD).
module uart_core #(
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int DIV_W      = 16,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 areset_n,
   input  logic [DIV_W-1:0]     divisor,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 rx_frame_err,
   output logic                 rx_parity_err,
   output logic [2:0]           tx_state_o,
   output logic [2:0]           rx_state_o
);

   // Handshake: a byte is taken on any posedge where tx_valid && tx_ready; tx_ready is high only in IDLE.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } state_e;

   logic [1:0]           rst_pipe_q;
   logic                 rst_n;
   logic [DIV_W-1:0]     cnt_q, cnt_d;
   logic                 tick;

   state_e               tx_state_q, tx_state_d;
   logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
   logic [3:0]           tx_tcnt_q, tx_tcnt_d;
   logic [3:0]           tx_bcnt_q, tx_bcnt_d;
   logic                 tx_bit_end;

   state_e               rx_state_q, rx_state_d;
   logic [1:0]           rx_sync_q;
   logic                 rx_s;
   logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
   logic [3:0]           rx_tcnt_q, rx_tcnt_d;
   logic [3:0]           rx_bcnt_q, rx_bcnt_d;
   logic                 rx_bit_end, rx_half;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 rx_valid_q, rx_valid_d;
   logic                 rx_ferr_q, rx_ferr_d;

`ifdef UART_PARITY_EN
   localparam logic PAR_SENSE = (PARITY_ODD != 0);
   logic tx_par_q, tx_par_d;
   logic rx_ppend_q, rx_ppend_d;
   logic rx_perr_q, rx_perr_d;
`endif

   // Reset asserts asynchronously but is released in step with clk.
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) rst_pipe_q <= 2'b00;
      else           rst_pipe_q <= {rst_pipe_q[0], 1'b1};
   end
   assign rst_n = rst_pipe_q[1];

   // ">=" so a divisor lowered below the current count still wraps at once.
   assign tick  = (divisor <= DIV_W'(1)) || (cnt_q >= divisor - DIV_W'(1));
   assign cnt_d = tick ? '0 : cnt_q + DIV_W'(1);

   assign tx_bit_end = tick && (tx_tcnt_q == 4'd15);
   assign rx_bit_end = tick && (rx_tcnt_q == 4'd15);
   assign rx_half    = tick && (rx_tcnt_q == 4'd7);
   assign rx_s       = rx_sync_q[1];

   always_comb begin
      tx_state_d = tx_state_q;
      tx_shift_d = tx_shift_q;
      tx_tcnt_d  = tick ? tx_tcnt_q + 4'd1 : tx_tcnt_q;
      tx_bcnt_d  = tx_bcnt_q;
`ifdef UART_PARITY_EN
      tx_par_d   = tx_par_q;
`endif
      case (tx_state_q)
         ST_IDLE: if (tx_valid) begin
            tx_state_d = ST_START;
            tx_shift_d = tx_data;
            tx_tcnt_d  = 4'd0;
            tx_bcnt_d  = 4'd0;
`ifdef UART_PARITY_EN
            tx_par_d   = (^tx_data) ^ PAR_SENSE;
`endif
         end
         ST_START: if (tx_bit_end) tx_state_d = ST_DATA;
         ST_DATA: if (tx_bit_end) begin
            tx_shift_d = tx_shift_q >> 1;
            tx_bcnt_d  = tx_bcnt_q + 4'd1;
            if (tx_bcnt_q == 4'(DATA_BITS - 1)) begin
               tx_bcnt_d  = 4'd0;
`ifdef UART_PARITY_EN
               tx_state_d = ST_PARITY;
`else
               tx_state_d = ST_STOP;
`endif
            end
         end
`ifdef UART_PARITY_EN
         ST_PARITY: if (tx_bit_end) tx_state_d = ST_STOP;
`endif
         ST_STOP: if (tx_bit_end) begin
            tx_bcnt_d = tx_bcnt_q + 4'd1;
            if (tx_bcnt_q == 4'(STOP_BITS - 1)) tx_state_d = ST_IDLE;
         end
         default: tx_state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      tx = 1'b1;
      case (tx_state_q)
         ST_START:  tx = 1'b0;
         ST_DATA:   tx = tx_shift_q[0];
`ifdef UART_PARITY_EN
         ST_PARITY: tx = tx_par_q;
`endif
         default:   tx = 1'b1;
      endcase
   end

   always_comb begin
      rx_state_d = rx_state_q;
      rx_shift_d = rx_shift_q;
      rx_tcnt_d  = tick ? rx_tcnt_q + 4'd1 : rx_tcnt_q;
      rx_bcnt_d  = rx_bcnt_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      rx_ferr_d  = rx_ferr_q;
`ifdef UART_PARITY_EN
      rx_ppend_d = rx_ppend_q;
      rx_perr_d  = rx_perr_q;
`endif
      case (rx_state_q)
         ST_IDLE: if (!rx_s) begin
            rx_state_d = ST_START;
            rx_tcnt_d  = 4'd0;
         end
         // Mid start bit: a line already back high was only a glitch.
         ST_START: if (rx_half) begin
            rx_tcnt_d  = 4'd0;
            rx_bcnt_d  = 4'd0;
            rx_state_d = rx_s ? ST_IDLE : ST_DATA;
         end
         ST_DATA: if (rx_bit_end) begin
            rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
            rx_bcnt_d  = rx_bcnt_q + 4'd1;
            if (rx_bcnt_q == 4'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
               rx_state_d = ST_PARITY;
`else
               rx_state_d = ST_STOP;
`endif
            end
         end
`ifdef UART_PARITY_EN
         ST_PARITY: if (rx_bit_end) begin
            rx_ppend_d = rx_s ^ (^rx_shift_q) ^ PAR_SENSE;
            rx_state_d = ST_STOP;
         end
`endif
         // Only the first stop bit is checked so a following start edge is caught early.
         ST_STOP: if (rx_bit_end) begin
            rx_state_d = ST_IDLE;
            rx_valid_d = 1'b1;
            rx_data_d  = rx_shift_q;
            rx_ferr_d  = ~rx_s;
`ifdef UART_PARITY_EN
            rx_perr_d  = rx_ppend_q;
`endif
         end
         default: rx_state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         tx_state_q <= ST_IDLE;
         tx_shift_q <= '0;
         tx_tcnt_q  <= 4'd0;
         tx_bcnt_q  <= 4'd0;
         rx_state_q <= ST_IDLE;
         rx_sync_q  <= 2'b11;
         rx_shift_q <= '0;
         rx_tcnt_q  <= 4'd0;
         rx_bcnt_q  <= 4'd0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_ferr_q  <= 1'b0;
`ifdef UART_PARITY_EN
         tx_par_q   <= 1'b0;
         rx_ppend_q <= 1'b0;
         rx_perr_q  <= 1'b0;
`endif
      end else begin
         cnt_q      <= cnt_d;
         tx_state_q <= tx_state_d;
         tx_shift_q <= tx_shift_d;
         tx_tcnt_q  <= tx_tcnt_d;
         tx_bcnt_q  <= tx_bcnt_d;
         rx_state_q <= rx_state_d;
         rx_sync_q  <= {rx_sync_q[0], rx};
         rx_shift_q <= rx_shift_d;
         rx_tcnt_q  <= rx_tcnt_d;
         rx_bcnt_q  <= rx_bcnt_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         rx_ferr_q  <= rx_ferr_d;
`ifdef UART_PARITY_EN
         tx_par_q   <= tx_par_d;
         rx_ppend_q <= rx_ppend_d;
         rx_perr_q  <= rx_perr_d;
`endif
      end
   end

   assign tx_ready     = (tx_state_q == ST_IDLE);
   assign rx_data      = rx_data_q;
   assign rx_valid     = rx_valid_q;
   assign rx_frame_err = rx_ferr_q;
   assign tx_state_o   = tx_state_q;
   assign rx_state_o   = rx_state_q;
`ifdef UART_PARITY_EN
   assign rx_parity_err = rx_perr_q;
`else
   // Constant 0; the comparison only keeps PARITY_ODD referenced in this build.
   assign rx_parity_err = (PARITY_ODD < 0);
`endif

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core: TX waveform, loopback, RX glitch, framing error, parity, mid-frame reset.
// Parity steps are compiled in only when UART_PARITY_EN is defined.
module tb_uart_core;

   logic        clk = 1'b0;
   logic        areset_n;
   logic [15:0] divisor;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        tx;
   logic        rx;
   logic        rx_drv;
   logic        loop_en;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_frame_err;
   logic        rx_parity_err;
   logic [2:0]  tx_state;
   logic [2:0]  rx_state;

   int n_assert = 0;
   int n_fail   = 0;
   int rx_cnt   = 0;
   int cyc      = 0;
   logic [9:0] exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   assign rx = loop_en ? tx : rx_drv;

   uart_core dut (
      .clk           (clk),
      .areset_n      (areset_n),
      .divisor       (divisor),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .tx            (tx),
      .rx            (rx),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_frame_err  (rx_frame_err),
      .rx_parity_err (rx_parity_err),
      .tx_state_o    (tx_state),
      .rx_state_o    (rx_state)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Scoreboard: every rx_valid pulse must match the next {parity_err, frame_err, data}.
   always @(negedge clk) begin
      if (rx_valid) begin
         rx_cnt++;
         if (exp_q.size() == 0) check("rx_unexpected_valid", 32'(rx_valid), 32'd0);
         else check("rx_frame", {22'd0, rx_parity_err, rx_frame_err, rx_data}, {22'd0, exp_q.pop_front()});
      end
   end

   // Sends one byte at divisor=1 and checks tx/tx_ready in every cycle of the frame.
   task automatic tx_frame_check(input logic [7:0] d, input logic [10:0] bits, input int nbits,
                                 input string tag);
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      for (int j = 0; j < nbits * 16; j++) begin
         check({tag, "_tx"}, 32'(tx), 32'(bits[j / 16]));
         check({tag, "_rdy_low"}, 32'(tx_ready), 32'd0);
         @(negedge clk);
      end
      check({tag, "_rdy_end"}, 32'(tx_ready), 32'd1);
      check({tag, "_tx_idle"}, 32'(tx), 32'd1);
   endtask

   // Drives one RX frame at divisor=1 (16 clocks per bit) followed by idle line.
   task automatic send_rx(input logic [7:0] d, input logic par_b, input bit use_par, input logic stop_b);
      rx_drv = 1'b0;
      repeat (16) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_drv = d[i];
         repeat (16) @(negedge clk);
      end
      if (use_par) begin
         rx_drv = par_b;
         repeat (16) @(negedge clk);
      end
      rx_drv = stop_b;
      repeat (16) @(negedge clk);
      rx_drv = 1'b1;
      repeat (24) @(negedge clk);
   endtask

   task automatic wait_rx(input int target, input int budget, input string tag);
      for (int i = 0; i < budget && rx_cnt < target; i++) @(negedge clk);
      check(tag, 32'(rx_cnt), 32'(target));
   endtask

   initial begin
      logic [7:0] t2_bytes [3];
      int         acc_cyc  [3];
      int         base;
      int         k;
      bit         saw_start;

      areset_n = 1'b0;
      divisor  = 16'd1;
      tx_data  = 8'h00;
      tx_valid = 1'b0;
      rx_drv   = 1'b1;
      loop_en  = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_tx_ready", 32'(tx_ready), 32'd1);
      check("rst_rx_valid", 32'(rx_valid), 32'd0);
      check("rst_rx_data", 32'(rx_data), 32'd0);
      check("rst_frame_err", 32'(rx_frame_err), 32'd0);
      check("rst_parity_err", 32'(rx_parity_err), 32'd0);
      check("rst_tx_state", 32'(tx_state), 32'd0);
      check("rst_rx_state", 32'(rx_state), 32'd0);
      areset_n = 1'b1;
      repeat (4) @(negedge clk);

      // 1: 0xA5 at divisor=1 -> bits 0,1,0,1,0,0,1,0,1,1, 16 clocks each
      check("t1_ready_before", 32'(tx_ready), 32'd1);
`ifdef UART_PARITY_EN
      tx_frame_check(8'hA5, 11'b101_0100_1010, 11, "t5_par_tx");
`else
      tx_frame_check(8'hA5, 11'b011_0100_1010, 10, "t1");
`endif
      repeat (5) @(negedge clk);

      // 2: loopback, divisor=3, back-to-back frames with tx_valid held
      divisor     = 16'd3;
      loop_en     = 1'b1;
      t2_bytes[0] = 8'h00;
      t2_bytes[1] = 8'hFF;
      t2_bytes[2] = 8'h3C;
      base        = rx_cnt;
      repeat (10) @(negedge clk);
      tx_valid = 1'b1;
      for (int b = 0; b < 3; b++) begin
         tx_data = t2_bytes[b];
         exp_q.push_back({2'b00, t2_bytes[b]});
         k = 0;
         while (!tx_ready && k < 600) begin
            @(negedge clk);
            k++;
         end
         check("t2_ready_timeout", 32'(tx_ready), 32'd1);
         @(negedge clk);
         acc_cyc[b] = cyc;
         check("t2_start_bit", 32'(tx), 32'd0);
         check("t2_ready_drop", 32'(tx_ready), 32'd0);
      end
      tx_valid = 1'b0;
      check("t2_gap_first", 32'((acc_cyc[1] - acc_cyc[0] >= 479) && (acc_cyc[1] - acc_cyc[0] <= 481)), 32'd1);
      check("t2_gap_b2b", 32'(acc_cyc[2] - acc_cyc[1]), 32'd480);
      wait_rx(base + 3, 700, "t2_rx_count");
      check("t2_no_err", {30'd0, rx_parity_err, rx_frame_err}, 32'd0);
      loop_en = 1'b0;
      divisor = 16'd1;
      repeat (20) @(negedge clk);

      // 3: 6-clock low glitch on rx is rejected
      base      = rx_cnt;
      saw_start = 1'b0;
      rx_drv    = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (rx_state == 3'd1) saw_start = 1'b1;
      end
      rx_drv = 1'b1;
      repeat (30) begin
         @(negedge clk);
         if (rx_state == 3'd1) saw_start = 1'b1;
      end
      check("t3_saw_start", 32'(saw_start), 32'd1);
      check("t3_no_valid", 32'(rx_cnt), 32'(base));
      check("t3_rx_idle", 32'(rx_state), 32'd0);

      // 4: stop bit 0 -> frame error, held until the next good frame clears it
      base = rx_cnt;
      exp_q.push_back({2'b01, 8'h55});
      send_rx(8'h55, 1'b0, 1'b0, 1'b0);
      wait_rx(base + 1, 50, "t4_bad_count");
      repeat (10) @(negedge clk);
      check("t4_ferr_hold", 32'(rx_frame_err), 32'd1);
      check("t4_data_hold", 32'(rx_data), 32'h55);
      exp_q.push_back({2'b00, 8'hC3});
`ifdef UART_PARITY_EN
      send_rx(8'hC3, 1'b0, 1'b1, 1'b1);
`else
      send_rx(8'hC3, 1'b0, 1'b0, 1'b1);
`endif
      wait_rx(base + 2, 50, "t4_good_count");
      check("t4_ferr_cleared", 32'(rx_frame_err), 32'd0);

`ifdef UART_PARITY_EN
      // 5: RX 0xA5 with parity 1 (even expects 0) -> parity error; correct parity clears it
      base = rx_cnt;
      exp_q.push_back({2'b10, 8'hA5});
      send_rx(8'hA5, 1'b1, 1'b1, 1'b1);
      exp_q.push_back({2'b00, 8'hA5});
      send_rx(8'hA5, 1'b0, 1'b1, 1'b1);
      wait_rx(base + 2, 50, "t5_rx_count");
`endif

      // 6: reset in the middle of TX and RX data bits
      base     = rx_cnt;
      tx_data  = 8'h3C;
      tx_valid = 1'b1;
      rx_drv   = 1'b0;
      @(negedge clk);
      tx_valid = 1'b0;
      repeat (60) @(negedge clk);
      check("t6_tx_busy", 32'(tx_ready), 32'd0);
      check("t6_rx_busy", 32'(rx_state), 32'd2);
      areset_n = 1'b0;
      #1;
      check("t6_rst_tx", 32'(tx), 32'd1);
      check("t6_rst_ready", 32'(tx_ready), 32'd1);
      rx_drv = 1'b1;
      repeat (3) @(negedge clk);
      check("t6_rst_rx_state", 32'(rx_state), 32'd0);
      areset_n = 1'b1;
      repeat (200) @(negedge clk);
      check("t6_no_valid", 32'(rx_cnt), 32'(base));
      loop_en = 1'b1;
      exp_q.push_back({2'b00, 8'h5A});
`ifdef UART_PARITY_EN
      tx_frame_check(8'h5A, 11'b100_1011_0100, 11, "t6_after");
`else
      tx_frame_check(8'h5A, 11'b010_1011_0100, 10, "t6_after");
`endif
      wait_rx(base + 1, 100, "t6_rx_count");
      loop_en = 1'b0;
      check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
